// File: rtl/escalator_pkg.sv
// escalator_pkg: shared types and constants for the escalator status UART link.
// Rev 1.0
`default_nettype none

package escalator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int         PKT_BYTES         = 3;

  // Packet layout: sync, status, sync^status.
  function automatic logic [7:0] pkt_byte(input logic [1:0] idx,
                                          input logic [7:0] sync,
                                          input logic [7:0] stat);
    logic [7:0] b;
    case (idx)
      2'd0:    b = sync;
      2'd1:    b = stat;
      default: b = sync ^ stat;
    endcase
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/escalator_baud_tick.sv
// escalator_baud_tick: bit-period counter; bit_tick marks the last cycle of each bit.
// Rev 1.0
`default_nettype none

module escalator_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Held at zero while disabled so every frame starts on a full bit period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = en && (cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/escalator_status_tx.sv
// escalator_status_tx: sends 3-byte status packets (sync, status, checksum) over 8N1 UART.
// Rev 1.0
`default_nettype none

module escalator_status_tx
  import escalator_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] status,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  tx_state_t  state, state_n;
  logic [2:0] bit_idx, bit_n;
  logic [1:0] byte_idx, byte_n;
  logic [7:0] status_lat, lat_n;
  logic       pend, pend_n;
  logic [7:0] pend_status, pstat_n;
  logic       tx_n, busy_n, done_n;
  logic       bit_tick;
  logic [7:0] cur_byte;
  logic [2:0] next_bit;

  escalator_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .en      (state != IDLE),
    .bit_tick(bit_tick)
  );

  assign cur_byte = pkt_byte(byte_idx, SYNC_BYTE, status_lat);
  assign next_bit = bit_idx + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_idx     <= '0;
      byte_idx    <= '0;
      status_lat  <= '0;
      pend        <= 1'b0;
      pend_status <= '0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      bit_idx     <= bit_n;
      byte_idx    <= byte_n;
      status_lat  <= lat_n;
      pend        <= pend_n;
      pend_status <= pstat_n;
      tx          <= tx_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    lat_n   = status_lat;
    pend_n  = pend;
    pstat_n = pend_status;
    tx_n    = tx;
    busy_n  = busy;
    done_n  = 1'b0;

    // Requests arriving mid-packet queue one follow-up; the newest status wins.
    if (start && state != IDLE) begin
      pend_n  = 1'b1;
      pstat_n = status;
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_n = START;
          lat_n   = status;
          byte_n  = '0;
          bit_n   = '0;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (bit_tick) begin
          state_n = DATA;
          bit_n   = '0;
          tx_n    = cur_byte[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            bit_n   = '0;
            tx_n    = 1'b1;
          end else begin
            bit_n = next_bit;
            tx_n  = cur_byte[next_bit];
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (byte_idx == 2'(PKT_BYTES - 1)) begin
            done_n = 1'b1;
            byte_n = '0;
            // A request on this very edge is the newest one, so it takes precedence.
            if (pend || start) begin
              state_n = START;
              tx_n    = 1'b0;
              lat_n   = start ? status : pend_status;
              pend_n  = 1'b0;
            end else begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end else begin
            byte_n  = byte_idx + 2'd1;
            state_n = START;
            tx_n    = 1'b0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_escalator_status_tx.sv
// tb_escalator_status_tx: timeline model of packet framing plus a UART decoder on each tx line.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_escalator_status_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [7:0] status  = 8'h00;
  logic [2:0] tx_w, busy_w, done_w;

  int checks = 0;
  int errors = 0;
  int cpb_of [3] = '{4, 2, 1023};

  always #5 clk = ~clk;

  escalator_status_tx #(.CLKS_PER_BIT(4), .SYNC_BYTE(8'hA5)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .status(status),
    .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));

  escalator_status_tx #(.CLKS_PER_BIT(2), .SYNC_BYTE(8'hA5)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .status(status),
    .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));

  escalator_status_tx #(.CLKS_PER_BIT(1023), .SYNC_BYTE(8'hA5)) dut_c (
    .clk(clk), .rst(rst), .start(start_b), .status(status),
    .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line level at offset t into a packet: 30 bit slots of c cycles each.
  function automatic logic exp_tx(input bit act, input int t, input int c, input logic [7:0] st);
    int b, p;
    logic [7:0] by;
    if (!act) return 1'b1;
    b = t / (10 * c);
    p = (t % (10 * c)) / c;
    case (b)
      0:       by = 8'hA5;
      1:       by = st;
      default: by = 8'hA5 ^ st;
    endcase
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return by[p-1];
  endfunction

  bit         m_act   [3];
  int         m_t     [3];
  logic [7:0] m_stat  [3];
  bit         m_pend  [3];
  logic [7:0] m_pstat [3];
  bit         e_done  [3];
  bit         m_s;
  int         cyc = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (!rst) cyc++;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_act[k]  = 1'b0;
        m_t[k]    = 0;
        m_pend[k] = 1'b0;
        e_done[k] = 1'b0;
      end else begin
        m_s       = (k == 0) ? start_a : start_b;
        e_done[k] = 1'b0;
        if (m_act[k]) begin
          m_t[k]++;
          if (m_t[k] == 30 * cpb_of[k]) begin
            e_done[k] = 1'b1;
            if (m_pend[k] || m_s) begin
              m_stat[k] = m_s ? status : m_pstat[k];
              m_t[k]    = 0;
              m_pend[k] = 1'b0;
            end else begin
              m_act[k] = 1'b0;
            end
          end else if (m_s) begin
            m_pend[k]  = 1'b1;
            m_pstat[k] = status;
          end
        end else if (m_s) begin
          m_act[k]  = 1'b1;
          m_t[k]    = 0;
          m_stat[k] = status;
        end
      end
    end
  end

  bit         checking = 1'b0;
  bit         rx_on [3];
  int         rx_c  [3];
  logic [7:0] rx_sh [3];
  logic [7:0] rxb   [3][16];
  int         rxn   [3];
  int         bc    [3];
  int         dc    [3];
  int         fall  [3];
  bit         pb    [3];
  int         ds    [4];

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (checking)
        chk($sformatf("model_inst%0d_tx_busy_done", k),
            {29'd0, tx_w[k], busy_w[k], done_w[k]},
            {29'd0, exp_tx(m_act[k], m_t[k], cpb_of[k], m_stat[k]), m_act[k], e_done[k]});
      if (busy_w[k] === 1'b1) bc[k]++;
      if (done_w[k] === 1'b1) begin
        if (k == 0 && dc[0] < 4) ds[dc[0]] = cyc;
        dc[k]++;
      end
      if (pb[k] && busy_w[k] === 1'b0) fall[k]++;
      pb[k] = (busy_w[k] === 1'b1);
      if (rst) begin
        rx_on[k] = 1'b0;
      end else if (!rx_on[k]) begin
        if (tx_w[k] === 1'b0) begin
          rx_on[k] = 1'b1;
          rx_c[k]  = 0;
        end
      end else begin
        rx_c[k]++;
        if (rx_c[k] == 9 * cpb_of[k] + cpb_of[k] / 2) begin
          if (rxn[k] < 16) rxb[k][rxn[k]] = rx_sh[k];
          rxn[k]++;
          rx_on[k] = 1'b0;
        end else if (rx_c[k] >= cpb_of[k] + cpb_of[k] / 2 &&
                     (rx_c[k] - cpb_of[k] / 2) % cpb_of[k] == 0) begin
          rx_sh[k] = {tx_w[k], rx_sh[k][7:1]};
        end
      end
    end
  end

  task automatic clear_stats();
    for (int k = 0; k < 3; k++) begin
      bc[k]   = 0;
      dc[k]   = 0;
      fall[k] = 0;
      rxn[k]  = 0;
    end
  endtask

  // Expected bytes packed MSB-first: byte i sits at exp[8*(8-i) +: 8].
  task automatic chk_bytes(input string name, input int k, input int n, input logic [71:0] exp);
    chk({name, "_count"}, rxn[k], n);
    for (int i = 0; i < n && i < 9; i++)
      chk($sformatf("%s_byte%0d", name, i), {24'd0, rxb[k][i]}, {24'd0, exp[8*(8-i) +: 8]});
  endtask

  task automatic wait_idle(input int k, input int maxc);
    int n;
    n = 0;
    while (busy_w[k] !== 1'b0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("idle_within_bound_inst%0d", k), {31'd0, n < maxc}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_a(input logic [7:0] st);
    status  = st;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_stats();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_tx_inst%0d", k),   {31'd0, tx_w[k]},   32'd1);
      chk($sformatf("reset_busy_inst%0d", k), {31'd0, busy_w[k]}, 32'd0);
      chk($sformatf("reset_done_inst%0d", k), {31'd0, done_w[k]}, 32'd0);
    end
    rst      = 1'b0;
    checking = 1'b1;
    @(negedge clk);

    // Bit-width extremes with status 5A.
    clear_stats();
    status  = 8'h5A;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    wait_idle(2, 31000);
    chk_bytes("cpb2", 1, 3, {8'hA5, 8'h5A, 8'hFF, 48'd0});
    chk_bytes("cpb1023", 2, 3, {8'hA5, 8'h5A, 8'hFF, 48'd0});
    chk("busy_len_cpb2", bc[1], 32'd60);
    chk("busy_len_cpb1023", bc[2], 32'd30690);
    chk("done_cnt_cpb2", dc[1], 32'd1);
    chk("done_cnt_cpb1023", dc[2], 32'd1);

    // Single packet; status changes after latch must not leak in.
    clear_stats();
    pulse_a(8'h3C);
    chk("first_cycle_tx", {31'd0, tx_w[0]}, 32'd0);
    chk("first_cycle_busy", {31'd0, busy_w[0]}, 32'd1);
    @(negedge clk);
    status = 8'hFF;
    wait_idle(0, 200);
    chk_bytes("single", 0, 3, {8'hA5, 8'h3C, 8'h99, 48'd0});
    chk("single_busy_len", bc[0], 32'd120);
    chk("single_done_cnt", dc[0], 32'd1);
    chk("single_busy_fall", fall[0], 32'd1);

    // Two requests mid-packet: only the latest status follows, with no gap.
    clear_stats();
    pulse_a(8'h3C);
    repeat (20) @(negedge clk);
    pulse_a(8'h01);
    repeat (20) @(negedge clk);
    pulse_a(8'h02);
    wait_idle(0, 400);
    chk_bytes("pending", 0, 6, {8'hA5, 8'h3C, 8'h99, 8'hA5, 8'h02, 8'hA7, 24'd0});
    chk("pending_busy_len", bc[0], 32'd240);
    chk("pending_done_cnt", dc[0], 32'd2);
    chk("pending_busy_fall", fall[0], 32'd1);

    // Asynchronous abort mid-packet, then a clean packet.
    clear_stats();
    pulse_a(8'h3C);
    repeat (49) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_tx", {31'd0, tx_w[0]}, 32'd1);
    chk("abort_busy", {31'd0, busy_w[0]}, 32'd0);
    chk("abort_done", {31'd0, done_w[0]}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_stats();
    pulse_a(8'h00);
    wait_idle(0, 200);
    chk_bytes("after_abort", 0, 3, {8'hA5, 8'h00, 8'hA5, 48'd0});
    chk("after_abort_busy_len", bc[0], 32'd120);
    chk("after_abort_done_cnt", dc[0], 32'd1);

    // start held for three packets; each latches the status present at its edge.
    clear_stats();
    status  = 8'h10;
    start_a = 1'b1;
    repeat (60) @(negedge clk);
    status = 8'h20;
    repeat (120) @(negedge clk);
    status = 8'h30;
    repeat (61) @(negedge clk);
    start_a = 1'b0;
    wait_idle(0, 400);
    chk_bytes("held", 0, 9, {8'hA5, 8'h10, 8'hB5, 8'hA5, 8'h20, 8'h85, 8'hA5, 8'h30, 8'h95});
    chk("held_done_cnt", dc[0], 32'd3);
    chk("held_busy_len", bc[0], 32'd360);
    chk("held_busy_fall", fall[0], 32'd1);
    chk("held_done_gap1", ds[1] - ds[0], 32'd120);
    chk("held_done_gap2", ds[2] - ds[1], 32'd120);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
